// File: rtl/skip_counter_reg.sv
// Modulo sequence/slot counter with hold/inc/dec/load commands, an optional
// skipped value, wrap or saturate boundary handling and clear on a status rise.
module skip_counter_reg #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned MOD_VAL  = 4,
    parameter int unsigned SKIP_EN  = 1,
    parameter int unsigned SKIP_VAL = 3,
    parameter int unsigned SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             status,
    input  logic [1:0]       count,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] register,
    output logic             wrap,
    output logic             sat,
    output logic             err
);

    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_INC  = 2'b01,
        CMD_DEC  = 2'b10,
        CMD_LOAD = 2'b11
    } cmd_e;

    // One extra bit so MOD_VAL == 2**WIDTH needs no special case.
    localparam logic [WIDTH:0] TOP   = (WIDTH+1)'(MOD_VAL - 1);
    localparam logic [WIDTH:0] MODV  = (WIDTH+1)'(MOD_VAL);
    localparam logic [WIDTH:0] SKIPV = (WIDTH+1)'(SKIP_VAL);
    localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);
    localparam logic           SKIP_ON = (SKIP_EN != 0);
    localparam logic           SAT_ON  = (SAT_MODE != 0);

    logic [WIDTH:0] cnt_q, cnt_d;
    logic           status_q;
    logic           wrap_d, sat_d, err_d;
    logic           rise;
    cmd_e           cmd;

    logic [WIDTH:0] inc_a, inc_b, dec_a, dec_b, ld_ext;
    logic           inc_skip, dec_skip, inc_x, dec_x, load_ok;

    assign register = cnt_q[WIDTH-1:0];
    assign rise     = status & ~status_q;
    assign cmd      = cmd_e'(count);

    // Single step, then a second step in the same direction if the first lands on the skip value.
    always_comb begin
        inc_a    = (cnt_q == TOP) ? '0 : cnt_q + ONE;
        inc_skip = SKIP_ON && (inc_a == SKIPV);
        inc_b    = (inc_a == TOP) ? '0 : inc_a + ONE;
        inc_x    = (cnt_q == TOP) || (inc_skip && (inc_a == TOP));

        dec_a    = (cnt_q == '0) ? TOP : cnt_q - ONE;
        dec_skip = SKIP_ON && (dec_a == SKIPV);
        dec_b    = (dec_a == '0) ? TOP : dec_a - ONE;
        dec_x    = (cnt_q == '0) || (dec_skip && (dec_a == '0));

        ld_ext   = {1'b0, load_data};
        load_ok  = (ld_ext < MODV) && !(SKIP_ON && (ld_ext == SKIPV));
    end

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        sat_d  = 1'b0;
        err_d  = 1'b0;
        if (rise) begin
            cnt_d = '0;
        end else if (!status) begin
            unique case (cmd)
                CMD_HOLD: cnt_d = cnt_q;
                CMD_INC: begin
                    if (inc_x && SAT_ON) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d  = inc_skip ? inc_b : inc_a;
                        wrap_d = inc_x;
                    end
                end
                CMD_DEC: begin
                    if (dec_x && SAT_ON) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d  = dec_skip ? dec_b : dec_a;
                        wrap_d = dec_x;
                    end
                end
                CMD_LOAD: begin
                    if (load_ok) cnt_d = ld_ext;
                    else         err_d = 1'b1;
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            status_q <= 1'b0;
            wrap     <= 1'b0;
            sat      <= 1'b0;
            err      <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            status_q <= status;
            wrap     <= wrap_d;
            sat      <= sat_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_skip_counter_reg.sv
// Scoreboard bench for skip_counter_reg: three configurations (default,
// 4-bit mod-10 skip-5 wrap, same in saturate) checked against a behavioural model.
module tb_skip_counter_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] st;
    logic [1:0] cmd [3];
    logic [3:0] ld  [3];
    logic [1:0] r0;
    logic [3:0] r1, r2;
    logic [2:0] w, s, e;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    int mod_a [3] = '{4, 10, 10};
    int skv_a [3] = '{3, 5, 5};
    bit sat_a [3] = '{1'b0, 1'b0, 1'b1};

    int m_r  [3];
    bit m_sq [3];

    typedef struct {
        int         d;
        string      tag;
        logic [6:0] exp;
    } exp_t;
    exp_t sbq [$];

    always #5 clk = ~clk;

    skip_counter_reg u_d0 (
        .clk(clk), .rst_n(rst_n), .status(st[0]), .count(cmd[0]),
        .load_data(ld[0][1:0]), .register(r0), .wrap(w[0]), .sat(s[0]), .err(e[0])
    );

    skip_counter_reg #(.WIDTH(4), .MOD_VAL(10), .SKIP_EN(1), .SKIP_VAL(5), .SAT_MODE(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .status(st[1]), .count(cmd[1]),
        .load_data(ld[1]), .register(r1), .wrap(w[1]), .sat(s[1]), .err(e[1])
    );

    skip_counter_reg #(.WIDTH(4), .MOD_VAL(10), .SKIP_EN(1), .SKIP_VAL(5), .SAT_MODE(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .status(st[2]), .count(cmd[2]),
        .load_data(ld[2]), .register(r2), .wrap(w[2]), .sat(s[2]), .err(e[2])
    );

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] obs(input int d);
        case (d)
            0:       return {2'b00, r0, w[0], s[0], e[0]};
            1:       return {r1, w[1], s[1], e[1]};
            default: return {r2, w[2], s[2], e[2]};
        endcase
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_r[d]  = 0;
            m_sq[d] = 1'b0;
        end
    endfunction

    // Advance every model by one clock edge; queue the expectation for the targeted instance.
    function automatic void model_edge(input int tgt, input string tag);
        for (int d = 0; d < 3; d++) begin
            int r  = m_r[d];
            bit fw = 1'b0;
            bit fs = 1'b0;
            bit fe = 1'b0;
            int v;
            int l;
            bit x;
            if (st[d] && !m_sq[d]) begin
                r = 0;
            end else if (!st[d]) begin
                case (cmd[d])
                    2'b01, 2'b10: begin
                        v = r;
                        x = 1'b0;
                        do begin
                            if (cmd[d] == 2'b01) begin
                                if (v == mod_a[d] - 1) begin v = 0; x = 1'b1; end
                                else v = v + 1;
                            end else begin
                                if (v == 0) begin v = mod_a[d] - 1; x = 1'b1; end
                                else v = v - 1;
                            end
                        end while (v == skv_a[d]);
                        if (x && sat_a[d]) fs = 1'b1;
                        else begin r = v; fw = x; end
                    end
                    2'b11: begin
                        l = (d == 0) ? int'(ld[d][1:0]) : int'(ld[d]);
                        if (l < mod_a[d] && l != skv_a[d]) r = l;
                        else fe = 1'b1;
                    end
                    default: ;
                endcase
            end
            m_sq[d] = st[d];
            m_r[d]  = r;
            if (d == tgt) sbq.push_back('{d, tag, {4'(r), fw, fs, fe}});
        end
    endfunction

    task automatic step(input int d, input logic s_in, input logic [1:0] c,
                        input logic [3:0] l, input string tag);
        exp_t x;
        @(negedge clk);
        st[d]  = s_in;
        cmd[d] = c;
        ld[d]  = l;
        model_edge(d, tag);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check({tag, "_noexp"}, 16'd1, 16'd0);
        end else begin
            x = sbq.pop_front();
            check(x.tag, obs(x.d), x.exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        st    = '0;
        for (int d = 0; d < 3; d++) begin
            cmd[d] = 2'b00;
            ld[d]  = '0;
        end
        model_reset();
        #3;
        for (int d = 0; d < 3; d++) check($sformatf("rst_d%0d", d), obs(d), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Default configuration: 1,2,0(wrap),1
        for (int i = 0; i < 4; i++) step(0, 1'b0, 2'b01, 4'd0, $sformatf("d0_inc%0d", i));
        step(0, 1'b0, 2'b11, 4'd3, "d0_ld_skip");
        step(0, 1'b0, 2'b11, 4'd2, "d0_ld2");

        // Mod-10, skip 5, wrap mode
        step(1, 1'b0, 2'b11, 4'd4, "d1_ld4");
        for (int i = 0; i < 6; i++) step(1, 1'b0, 2'b10, 4'd0, $sformatf("d1_dec%0d", i));
        step(1, 1'b0, 2'b11, 4'd4, "d1_ld4b");
        step(1, 1'b0, 2'b01, 4'd0, "d1_inc_skip");
        step(1, 1'b0, 2'b11, 4'd5, "d1_ld_skip");
        step(1, 1'b0, 2'b11, 4'd12, "d1_ld_big");
        step(1, 1'b0, 2'b11, 4'd7, "d1_ld7");
        step(1, 1'b1, 2'b01, 4'd0, "d1_st_rise");
        for (int i = 0; i < 3; i++) step(1, 1'b1, 2'b01, 4'd0, $sformatf("d1_st_hold%0d", i));
        step(1, 1'b0, 2'b01, 4'd0, "d1_st_drop_inc");
        step(1, 1'b0, 2'b11, 4'd9, "d1_ld9");
        step(1, 1'b0, 2'b01, 4'd0, "d1_inc_wrap9");

        // Saturate mode
        step(2, 1'b0, 2'b11, 4'd9, "d2_ld9");
        step(2, 1'b0, 2'b01, 4'd0, "d2_inc_sat");
        step(2, 1'b0, 2'b11, 4'd0, "d2_ld0");
        step(2, 1'b0, 2'b10, 4'd0, "d2_dec_sat");
        step(2, 1'b0, 2'b11, 4'd4, "d2_ld4");
        step(2, 1'b0, 2'b01, 4'd0, "d2_inc_skip");
        step(2, 1'b0, 2'b11, 4'd6, "d2_ld6");
        step(2, 1'b0, 2'b10, 4'd0, "d2_dec_skip");

        // Asynchronous reset between edges, released with status high
        step(1, 1'b0, 2'b11, 4'd6, "d1_ld6");
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check($sformatf("arst_d%0d", d), obs(d), 16'd0);
        model_reset();
        st[1]  = 1'b1;
        cmd[1] = 2'b01;
        rst_n  = 1'b1;
        step(1, 1'b1, 2'b01, 4'd0, "d1_rel_clr");
        step(1, 1'b0, 2'b01, 4'd0, "d1_rel_inc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
